// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch unit.
//   state_e   - fetch state machine encoding (IDLE, REQ, WAIT, HOLD)
//   NOP_INSTR - canonical NOP (addi x0, x0, 0), used as the reset value of
//               the instruction register and as the payload of a faulting fetch
//   XLEN      - address / instruction width (only 32 is supported)
package fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_HOLD = 2'd3
  } state_e;

endpackage : fetch_pkg

// File: rtl/instr_fetch.sv
// instr_fetch: single-issue instruction fetch unit.
//
// Watches the committed PC, issues one memory request per new PC, and hands
// the returned word to decode. A PC change while a fetch is in flight squashes
// that fetch; the new PC is then fetched.
//
// Ports:
//   clk_i          clock, rising edge
//   i_rst          asynchronous active-high reset
//   pc_i           committed PC
//   imem_req_o     memory request valid
//   imem_addr_o    memory request address
//   imem_gnt_i     memory request accepted
//   imem_rvalid_i  memory read data valid (at least one cycle after gnt)
//   imem_rdata_i   memory read data
//   instr_valid_o  instruction available to decode
//   instr_o        instruction word
//   instr_pc_o     address of instr_o
//   fault_o        misaligned fetch, qualified by instr_valid_o
//   instr_ready_i  decode accepts the instruction
//
// Handshakes:
//   Memory side: a request transfers on a cycle where imem_req_o and imem_gnt_i
//   are both high; until then imem_req_o stays high and imem_addr_o stays stable
//   unless the PC changes, in which case the request is dropped. Each granted
//   request yields exactly one imem_rvalid_i pulse, which is always consumed.
//   Decode side: an instruction transfers on a cycle where instr_valid_o and
//   instr_ready_i are both high. While valid is high, instr_o, instr_pc_o and
//   fault_o are stable; valid is only withdrawn without a transfer when the PC
//   moves away from the held instruction's address (squash).
//
// All outputs come straight from flops; there is no input-to-output path.
module instr_fetch #(
  parameter int XLEN = 32  // only 32 is supported
) (
  input  logic            clk_i,
  input  logic            i_rst,
  input  logic [XLEN-1:0] pc_i,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  output logic            instr_valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] instr_pc_o,
  output logic            fault_o,
  input  logic            instr_ready_i
);

  import fetch_pkg::state_e;
  import fetch_pkg::ST_IDLE;
  import fetch_pkg::ST_REQ;
  import fetch_pkg::ST_WAIT;
  import fetch_pkg::ST_HOLD;
  import fetch_pkg::NOP_INSTR;

  state_e          state_q, state_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;    // address in flight / held
  logic [XLEN-1:0] last_pc_q, last_pc_d;  // last address delivered to decode
  logic            first_q, first_d;      // nothing delivered since reset
  logic [XLEN-1:0] instr_q, instr_d;
  logic            fault_q, fault_d;

  logic fetch_needed;
  logic stale;

  // first_q forces a fetch after reset even when pc_i equals last_pc_q (0).
  assign fetch_needed = first_q | (pc_i != last_pc_q);
  assign stale        = (pc_i != req_pc_q);

  always_comb begin
    state_d   = state_q;
    req_pc_d  = req_pc_q;
    last_pc_d = last_pc_q;
    first_d   = first_q;
    instr_d   = instr_q;
    fault_d   = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (fetch_needed) begin
          req_pc_d = pc_i;
          if (pc_i[1:0] == 2'b00) begin
            state_d = ST_REQ;
          end else begin
            // Misaligned: present a NOP flagged as a fault, no memory access.
            instr_d = NOP_INSTR;
            fault_d = 1'b1;
            state_d = ST_HOLD;
          end
        end
      end

      ST_REQ: begin
        // A grant wins over a simultaneous PC change: the request has been
        // accepted, so its response must be drained in WAIT.
        if (imem_gnt_i) begin
          state_d = ST_WAIT;
        end else if (stale) begin
          state_d = ST_IDLE;
        end
      end

      ST_WAIT: begin
        // Stay here on a stale PC until the response arrives so that it can
        // be drained rather than mistaken for the next fetch's data.
        if (imem_rvalid_i) begin
          if (!stale) begin
            instr_d = imem_rdata_i;
            fault_d = 1'b0;
            state_d = ST_HOLD;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_HOLD: begin
        // A transfer completes even if the PC moves in the same cycle; the
        // following IDLE then sees fetch_needed and fetches the new PC.
        if (instr_ready_i) begin
          last_pc_d = req_pc_q;
          first_d   = 1'b0;
          state_d   = ST_IDLE;
        end else if (stale) begin
          state_d = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      req_pc_q  <= '0;
      last_pc_q <= '0;
      first_q   <= 1'b1;
      instr_q   <= NOP_INSTR;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      req_pc_q  <= req_pc_d;
      last_pc_q <= last_pc_d;
      first_q   <= first_d;
      instr_q   <= instr_d;
      fault_q   <= fault_d;
    end
  end

  assign imem_req_o    = (state_q == ST_REQ);
  assign imem_addr_o   = req_pc_q;
  assign instr_valid_o = (state_q == ST_HOLD);
  assign instr_o       = instr_q;
  assign instr_pc_o    = req_pc_q;
  assign fault_o       = fault_q;

endmodule : instr_fetch

// File: doc/instr_fetch.md
# instr_fetch

Single-issue instruction fetch unit: the reader side of the `pc` register. It watches the committed PC value, issues one request per new PC to instruction memory over a req/gnt/rvalid interface, and presents the returned word to decode with a valid/ready handshake. A PC change while a fetch is in flight squashes that fetch, and the new address is fetched.

## Interface
Parameters:
- `XLEN`, 32: address and instruction width; only 32 is supported.

Ports:
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `i_rst`  input  1  reset, asynchronous and active-high.
- `pc_i`  input  XLEN  committed PC, driven by `pc.data_o`.
- `imem_req_o`  output  1  memory request valid.
- `imem_addr_o`  output  XLEN  request address; held stable while `imem_req_o`=1 and `imem_gnt_i`=0.
- `imem_gnt_i`  input  1  request accepted.
- `imem_rvalid_i`  input  1  read data valid; asserts at least 1 cycle after gnt.
- `imem_rdata_i`  input  XLEN  read data.
- `instr_valid_o`  output  1  instruction available to decode.
- `instr_o`  output  XLEN  instruction word.
- `instr_pc_o`  output  XLEN  address of `instr_o`.
- `fault_o`  output  1  misaligned-fetch flag, qualified by `instr_valid_o`.
- `instr_ready_i`  input  1  decode accepts the instruction.

## Operation
- Internal registers:
  - `req_pc_q`: address in flight.
  - `last_pc_q`: last delivered address.
  - `first_q`: set by reset, cleared on the first delivery.
- `fetch_needed = first_q | (pc_i != last_pc_q)`.
- `stale = (pc_i != req_pc_q)`.
- State machine states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - If `fetch_needed` and `pc_i[1:0]`==0: latch `req_pc_q`=`pc_i`, go to REQ.
  - If `fetch_needed` and `pc_i[1:0]`!=0: latch `req_pc_q`; load `instr_o`=NOP (0x0000_0013) and `fault_o`=1; go to HOLD with no memory access.
- REQ:
  - `imem_req_o`=1 and `imem_addr_o`=`req_pc_q`.
  - On `imem_gnt_i`, go to WAIT.
  - If `stale` before gnt: drop the request (`imem_req_o`=0 next cycle) and go to IDLE.
- WAIT:
  - On `imem_rvalid_i` with not `stale`: capture `imem_rdata_i` into `instr_o`, set `fault_o`=0, go to HOLD.
  - On `imem_rvalid_i` with `stale`: discard the data and go to IDLE.
  - A `stale` condition without `imem_rvalid_i` keeps WAIT, because the response must still be drained.
- HOLD:
  - `instr_valid_o`=1, and `instr_o`/`instr_pc_o` are stable.
  - On `instr_ready_i`: `last_pc_q`<=`req_pc_q`, `first_q`<=0, go to IDLE.
  - If `stale` and not `instr_ready_i`: deassert valid next cycle and go to IDLE (squash). This is the only permitted valid withdrawal.
- `imem_rvalid_i` in IDLE, REQ or HOLD is ignored; this covers a response orphaned by reset.
- `instr_pc_o` = `req_pc_q`.

## Timing
- All outputs are registered or decoded from the state register; there are no combinational paths from inputs to outputs.
- Reset values:
  - `imem_req_o`=0, `imem_addr_o`=0.
  - `instr_valid_o`=0, `instr_o`=0x0000_0013, `instr_pc_o`=0, `fault_o`=0.
  - State = IDLE, `first_q`=1, `last_pc_q`=0, `req_pc_q`=0.
- After reset release, a fetch of `pc_i` starts without waiting for a PC change.
- `pc_i` changes in cycle N:
  - `imem_req_o` rises in N+1.
  - With gnt in N+1 and rvalid in N+2, `instr_valid_o` rises in N+3.
  - Minimum latency from PC change to valid is 3 cycles.
- Misaligned fetch: `instr_valid_o` with `fault_o`=1 rises in N+1.
- Back-to-back: with ready high in HOLD and the PC unchanged, the block stays in IDLE until `pc_i` changes.
- Simultaneous `instr_ready_i` and `stale` in HOLD: the handshake completes (instruction delivered); the next IDLE sees `fetch_needed` and fetches the new PC.
- Reset mid-fetch: everything returns to reset values immediately (asynchronous); an outstanding memory response is dropped.

## Structure
- `fetch_pkg` holds:
  - the state enum (IDLE, REQ, WAIT, HOLD);
  - `NOP_INSTR` = 32'h0000_0013;
  - `XLEN`.
- One module, no sub-module.

## Test plan
- Reset release with `pc_i`=0, gnt the same cycle as req, rvalid 1 cycle later with data 0x0050_0093, ready=1 -> `imem_addr_o`=0, then `instr_valid_o`=1 with `instr_o`=0x0050_0093 and `instr_pc_o`=0, exactly 3 cycles after release.
- After delivery, hold `pc_i` constant for 10 cycles -> no further `imem_req_o`. Change `pc_i` to 0x4 -> request at 0x4 the next cycle.
- Stall gnt for 4 cycles -> `imem_addr_o` stable and `imem_req_o` held high. Then hold ready=0 for 3 cycles in HOLD -> `instr_o` stable and valid held.
- Change `pc_i` from 0x8 to 0x20 while in WAIT -> the rvalid for 0x8 produces no `instr_valid_o`; the next request is at 0x20 and delivers with `instr_pc_o`=0x20.
- `pc_i`=0x6 -> no memory request; `instr_valid_o`=1, `fault_o`=1, `instr_o`=0x0000_0013, `instr_pc_o`=0x6.
- Assert `i_rst` during WAIT, then drive rvalid after release -> the response is ignored, outputs are at reset values, and a fresh fetch of `pc_i` is issued.
